// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC owner, single-outstanding imem requester,
// registered prefetch queue toward decode. Define FETCH_PERF_EN to add perf counters.
module fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 INSTR_W  = 16,
  parameter int                 QDEPTH   = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [ADDR_W-1:0]  PC_INC   = ADDR_W'(2),
  parameter logic [3:0]         HALT_OPC = 4'hF
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic [ADDR_W-1:0]   pc,
  output logic                hlt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } req_state_t;

  req_state_t state_q, state_d;

  logic                run_q;
  logic                drop_q;
  logic                halt_seen_q;
  logic                hlt_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W:0]      count_q;
  logic [PTR_W:0]      occupancy;

  logic [INSTR_W-1:0]  q_data [QDEPTH];
  logic [ADDR_W-1:0]   q_addr [QDEPTH];

  logic                ack_seen;
  logic                flush;
  logic                push;
  logic                pop;
  logic                issue;
  logic [INSTR_W-1:0]  head_data;
  logic [ADDR_W-1:0]   head_addr;

  // An in-flight request reserves a queue slot so its ack can always be pushed.
  assign occupancy = count_q + {{PTR_W{1'b0}}, (state_q == S_WAIT)};

  assign head_data   = q_data[rd_ptr_q];
  assign head_addr   = q_addr[rd_ptr_q];
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? head_data : '0;
  assign instr_pc    = instr_valid ? head_addr : '0;

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign hlt       = hlt_q;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    flush    = redirect_valid & ~hlt_q;
    ack_seen = (state_q == S_WAIT) & imem_ack & ~hlt_q;
    push     = ack_seen & ~drop_q & ~flush;
    pop      = instr_valid & instr_ready & ~flush;
    issue    = run_q & (state_q == S_IDLE) & ~halt_seen_q & ~hlt_q & ~redirect_valid
             & (occupancy < (PTR_W+1)'(QDEPTH));

    case (state_q)
      S_IDLE:  if (issue)    state_d = S_WAIT;
      S_WAIT:  if (ack_seen) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      drop_q      <= 1'b0;
      halt_seen_q <= 1'b0;
      hlt_q       <= 1'b0;
      pc_q        <= RESET_PC;
      req_addr_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;

      if (pop && (head_data[INSTR_W-1 -: 4] == HALT_OPC)) hlt_q <= 1'b1;

      if (flush) begin
        pc_q        <= redirect_pc;
        halt_seen_q <= 1'b0;
        // A request still in flight after this cycle returns stale data.
        drop_q      <= (state_q == S_WAIT) & ~imem_ack;
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
        count_q     <= '0;
      end else begin
        if (issue) begin
          pc_q       <= pc_q + PC_INC;
          req_addr_q <= pc_q;
        end
        if (ack_seen) drop_q <= 1'b0;
        if (push && (imem_rdata[INSTR_W-1 -: 4] == HALT_OPC)) halt_seen_q <= 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

  // NOTE: queue storage has no reset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr_q] <= imem_rdata;
      q_addr[wr_ptr_q] <= req_addr_q;
    end
  end

`ifdef FETCH_PERF_EN
  // push and flush are already gated by hlt, which freezes both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && (perf_fetch_cnt != 32'hFFFF_FFFF)) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (flush && (perf_flush_cnt != 32'hFFFF_FFFF)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
